uart_console_bridge: RTL and testbench

//  Hardware bus master for the iob_uart native slave port (uart_valid/addr/wdata/wstrb/rdata/ready).

---
 rtl/uart_console_bridge.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_console_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_console_bridge.sv
// Bus master for the iob_uart native slave port. It initialises the UART, then polls it and moves
// bytes between the UART and the rx_*/tx_* byte streams.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// INIT0    | write SOFTRESET=1
// INIT1    | write SOFTRESET=0
// INIT2    | write DIV=DIV_VAL
// INIT3    | write TXEN=1
// INIT4    | write RXEN=1, init_done set on ack
// POLL_RX  | read RXREADY (skipped while the rx buffer holds a byte)
// READ_RX  | read RXDATA into the rx buffer
// POLL_TX  | read TXREADY (skipped while the tx buffer is empty)
// WRITE_TX | write the buffered tx byte to TXDATA
module uart_console_bridge #(
    parameter int          ADDR_W      = 3,
    parameter int          DATA_W      = 32,
    parameter logic [15:0] DIV_VAL     = 16'd100,
    parameter int          SOFTRESET_A = 0,
    parameter int          DIV_A       = 2,
    parameter int          TXDATA_A    = 4,
    parameter int          TXEN_A      = 5,
    parameter int          RXEN_A      = 6,
    parameter int          TXREADY_A   = 0,
    parameter int          RXREADY_A   = 1,
    parameter int          RXDATA_A    = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_done,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              uart_valid,
    output logic [ADDR_W-1:0] uart_addr,
    output logic [DATA_W-1:0] uart_wdata,
    output logic [3:0]        uart_wstrb,
    input  logic [DATA_W-1:0] uart_rdata,
    input  logic              uart_ready
);

    localparam logic [ADDR_W-1:0] SOFTRESET_AD = ADDR_W'(SOFTRESET_A);
    localparam logic [ADDR_W-1:0] DIV_AD       = ADDR_W'(DIV_A);
    localparam logic [ADDR_W-1:0] TXDATA_AD    = ADDR_W'(TXDATA_A);
    localparam logic [ADDR_W-1:0] TXEN_AD      = ADDR_W'(TXEN_A);
    localparam logic [ADDR_W-1:0] RXEN_AD      = ADDR_W'(RXEN_A);
    localparam logic [ADDR_W-1:0] TXREADY_AD   = ADDR_W'(TXREADY_A);
    localparam logic [ADDR_W-1:0] RXREADY_AD   = ADDR_W'(RXREADY_A);
    localparam logic [ADDR_W-1:0] RXDATA_AD    = ADDR_W'(RXDATA_A);

    typedef enum logic [3:0] {
        INIT0,
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        POLL_RX,
        READ_RX,
        POLL_TX,
        WRITE_TX
    } state_t;

    state_t              state_q, state_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                init_done_q, init_done_d;
    logic                rx_valid_q, rx_valid_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic                tx_full_q, tx_full_d;
    logic [7:0]          tx_byte_q, tx_byte_d;

    logic                start;
    logic                ack;
    logic                need;
    logic                req_wr;
    logic                req_two;
    logic [ADDR_W-1:0]   req_addr;
    logic [15:0]         req_val;
    logic [7:0]          rd_byte;
    logic                tx_ready_w;

    function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] lane, input logic [15:0] v);
        return DATA_W'(v) << {lane, 3'b000};
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] lane, input logic two);
        return (two ? 4'b0011 : 4'b0001) << lane;
    endfunction

    // A new request may only be launched from an idle bus cycle; the ack clears valid_q,
    // so the cycle after every ack is idle by construction.
    assign start      = !valid_q;
    assign ack        = valid_q && uart_ready;
    assign rd_byte    = uart_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign tx_ready_w = init_done_q && !tx_full_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        init_done_d = init_done_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        tx_full_d   = tx_full_q;
        tx_byte_d   = tx_byte_q;
        need        = 1'b0;
        req_wr      = 1'b0;
        req_two     = 1'b0;
        req_addr    = '0;
        req_val     = '0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (tx_valid && tx_ready_w) begin
            tx_full_d = 1'b1;
            tx_byte_d = tx_data;
        end

        case (state_q)
            INIT0: begin
                need     = 1'b1;
                req_wr   = 1'b1;
                req_addr = SOFTRESET_AD;
                req_val  = 16'd1;
                if (ack) state_d = INIT1;
            end
            INIT1: begin
                need     = 1'b1;
                req_wr   = 1'b1;
                req_addr = SOFTRESET_AD;
                req_val  = 16'd0;
                if (ack) state_d = INIT2;
            end
            INIT2: begin
                need     = 1'b1;
                req_wr   = 1'b1;
                req_two  = 1'b1;
                req_addr = DIV_AD;
                req_val  = DIV_VAL;
                if (ack) state_d = INIT3;
            end
            INIT3: begin
                need     = 1'b1;
                req_wr   = 1'b1;
                req_addr = TXEN_AD;
                req_val  = 16'd1;
                if (ack) state_d = INIT4;
            end
            INIT4: begin
                need     = 1'b1;
                req_wr   = 1'b1;
                req_addr = RXEN_AD;
                req_val  = 16'd1;
                if (ack) begin
                    init_done_d = 1'b1;
                    state_d     = POLL_RX;
                end
            end
            POLL_RX: begin
                req_addr = RXREADY_AD;
                if (start) begin
                    if (rx_valid_q) state_d = POLL_TX;
                    else            need    = 1'b1;
                end
                if (ack) state_d = rd_byte[0] ? READ_RX : POLL_TX;
            end
            READ_RX: begin
                need     = 1'b1;
                req_addr = RXDATA_AD;
                if (ack) begin
                    rx_data_d  = rd_byte;
                    rx_valid_d = 1'b1;
                    state_d    = POLL_TX;
                end
            end
            POLL_TX: begin
                req_addr = TXREADY_AD;
                if (start) begin
                    if (!tx_full_q) state_d = POLL_RX;
                    else            need    = 1'b1;
                end
                if (ack) state_d = rd_byte[0] ? WRITE_TX : POLL_RX;
            end
            WRITE_TX: begin
                need     = 1'b1;
                req_wr   = 1'b1;
                req_addr = TXDATA_AD;
                req_val  = {8'h00, tx_byte_q};
                if (ack) begin
                    tx_full_d = 1'b0;
                    state_d   = POLL_RX;
                end
            end
            default: begin
                state_d = INIT0;
            end
        endcase

        if (start && need) begin
            valid_d = 1'b1;
            addr_d  = req_addr;
            wdata_d = req_wr ? lane_data(req_addr[1:0], req_val) : '0;
            wstrb_d = req_wr ? lane_strb(req_addr[1:0], req_two) : 4'b0000;
        end else if (ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= INIT0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= 4'b0000;
            init_done_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            tx_full_q   <= 1'b0;
            tx_byte_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            init_done_q <= init_done_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            tx_full_q   <= tx_full_d;
            tx_byte_q   <= tx_byte_d;
        end
    end

    assign init_done  = init_done_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign tx_ready   = tx_ready_w;
    assign uart_valid = valid_q;
    assign uart_addr  = addr_q;
    assign uart_wdata = wdata_q;
    assign uart_wstrb = wstrb_q;

endmodule

// File: tb/tb_uart_console_bridge.sv
// Bench for uart_console_bridge: a UART slave model with programmable ack latency, a bus/stream
// monitor that checks writes and rx bytes against scoreboard queues, and directed scenarios.
module tb_uart_console_bridge;

    logic        clk;
    logic        reset;
    logic        init_done;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        uart_valid;
    logic [2:0]  uart_addr;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;
    logic [31:0] uart_rdata;
    logic        uart_ready;

    uart_console_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .init_done  (init_done),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_valid (uart_valid),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [38:0] exp_wr[$];
    logic [7:0]  exp_rx[$];

    // model controls (written by stimulus only)
    int       lat            = 0;
    int       rx_avail_until = 0;
    int       tx_zero_target = 0;
    logic [7:0] rx_byte      = 8'h00;

    // monitor counters (written by monitor only)
    int rxready_reads   = 0;
    int rxdata_reads    = 0;
    int txready_reads   = 0;
    int txdata_writes   = 0;
    int rx_hs           = 0;
    int rx_valid_cycles = 0;
    int last_hold       = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [38:0] wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        return {a, d, s};
    endfunction

    function automatic logic [31:0] model_rdata(input logic [2:0] a);
        logic [31:0] r;
        logic [7:0]  b;
        r = 32'hEEEE_EEEE;
        b = 8'h00;
        case (a)
            3'd1:    b = {7'd0, rxdata_reads < rx_avail_until};
            3'd0:    b = {7'd0, txready_reads >= tx_zero_target};
            3'd4:    b = rx_byte;
            default: b = 8'h00;
        endcase
        r[{a[1:0], 3'b000} +: 8] = b;
        return r;
    endfunction

    // UART slave: asserts a one-cycle uart_ready after lat wait cycles
    initial begin
        int cnt;
        cnt        = 0;
        uart_ready = 1'b0;
        uart_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (uart_ready) begin
                uart_ready = 1'b0;
                cnt        = 0;
            end else if (uart_valid) begin
                if (cnt >= lat) begin
                    uart_ready = 1'b1;
                    uart_rdata = model_rdata(uart_addr);
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: bus stability, write scoreboard, read counting, rx scoreboard
    initial begin
        logic        in_txn;
        logic        changed;
        logic        drop_pending;
        int          hold;
        logic [38:0] saved;
        logic [38:0] e;
        logic [7:0]  er;
        in_txn       = 1'b0;
        changed      = 1'b0;
        drop_pending = 1'b0;
        hold         = 0;
        saved        = '0;
        forever begin
            @(negedge clk);
            if (drop_pending) begin
                check("valid_drop_after_ack", 64'(uart_valid), 64'd0);
                drop_pending = 1'b0;
            end
            if (uart_valid) begin
                if (!in_txn) begin
                    in_txn  = 1'b1;
                    hold    = 1;
                    changed = 1'b0;
                    saved   = {uart_addr, uart_wdata, uart_wstrb};
                end else begin
                    hold++;
                    if ({uart_addr, uart_wdata, uart_wstrb} !== saved) changed = 1'b1;
                end
                if (uart_ready) begin
                    check("req_stable", 64'(changed), 64'd0);
                    last_hold    = hold;
                    in_txn       = 1'b0;
                    drop_pending = 1'b1;
                    if (uart_wstrb != 4'b0000) begin
                        if (uart_addr == 3'd4) txdata_writes++;
                        check("write_expected", 64'(exp_wr.size() > 0), 64'd1);
                        if (exp_wr.size() > 0) begin
                            e = exp_wr.pop_front();
                            check("bus_write", 64'({uart_addr, uart_wdata, uart_wstrb}), 64'(e));
                        end
                    end else begin
                        case (uart_addr)
                            3'd0:    txready_reads++;
                            3'd1:    rxready_reads++;
                            3'd4:    rxdata_reads++;
                            default: check("read_addr_legal", 64'(uart_addr), 64'd1);
                        endcase
                    end
                end
            end else begin
                in_txn = 1'b0;
            end
            if (rx_valid) rx_valid_cycles++;
            if (rx_valid && rx_ready) begin
                rx_hs++;
                check("rx_expected", 64'(exp_rx.size() > 0), 64'd1);
                if (exp_rx.size() > 0) begin
                    er = exp_rx.pop_front();
                    check("rx_byte", 64'(rx_data), 64'(er));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_init();
        exp_wr.push_back(wr(3'd0, 32'h0000_0001, 4'b0001));
        exp_wr.push_back(wr(3'd0, 32'h0000_0000, 4'b0001));
        exp_wr.push_back(wr(3'd2, 32'h0064_0000, 4'b1100));
        exp_wr.push_back(wr(3'd5, 32'h0000_0100, 4'b0010));
        exp_wr.push_back(wr(3'd6, 32'h0001_0000, 4'b0100));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_uart_valid"}, 64'(uart_valid), 64'd0);
        check({tag, "_uart_wstrb"}, 64'(uart_wstrb), 64'd0);
        check({tag, "_uart_addr"},  64'(uart_addr),  64'd0);
        check({tag, "_uart_wdata"}, 64'(uart_wdata), 64'd0);
        check({tag, "_rx_valid"},   64'(rx_valid),   64'd0);
        check({tag, "_rx_data"},    64'(rx_data),    64'd0);
        check({tag, "_tx_ready"},   64'(tx_ready),   64'd0);
        check({tag, "_init_done"},  64'(init_done),  64'd0);
    endtask

    task automatic wait_init(input string tag);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (init_done) break;
        end
        check({tag, "_init_done"}, 64'(init_done), 64'd1);
        check({tag, "_init_writes_left"}, 64'(exp_wr.size()), 64'd0);
        tick();
        check({tag, "_tx_ready_idle"}, 64'(tx_ready), 64'd1);
    endtask

    task automatic send_tx(input logic [7:0] b);
        for (int i = 0; i < 400; i++) begin
            if (tx_ready) break;
            tick();
        end
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        tx_valid = 1'b0;
        check("tx_ready_after_capture", 64'(tx_ready), 64'd0);
    endtask

    task automatic wait_tx_free();
        for (int i = 0; i < 800; i++) begin
            tick();
            if (tx_ready) break;
        end
        check("tx_ready_returns", 64'(tx_ready), 64'd1);
    endtask

    initial begin
        int snap_a;
        int snap_b;
        int snap_c;
        logic found;
        reset    = 1'b0;
        rx_ready = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // 1. reset values and init sequence
        repeat (3) tick();
        check_reset_outputs("reset");
        push_init();
        reset = 1'b1;
        wait_init("init");

        // 2. one rx byte with rx_ready held high
        snap_a  = rx_valid_cycles;
        snap_b  = rxdata_reads;
        rx_byte = 8'h41;
        exp_rx.push_back(8'h41);
        rx_avail_until = rxdata_reads + 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rx_hs >= 1) break;
        end
        check("rx1_handshake", 64'(rx_hs), 64'd1);
        repeat (10) tick();
        check("rx1_valid_cycles", 64'(rx_valid_cycles - snap_a), 64'd1);
        check("rx1_data_reads", 64'(rxdata_reads - snap_b), 64'd1);

        // 3. rx_ready low, RXREADY stuck at 1: one read then polling of RX stops
        rx_ready = 1'b0;
        snap_b   = rxdata_reads;
        rx_byte  = 8'h52;
        rx_avail_until = rxdata_reads + 1000;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rx_valid) break;
        end
        check("rx2_valid", 64'(rx_valid), 64'd1);
        check("rx2_data", 64'(rx_data), 64'h52);
        snap_c = rxready_reads;
        repeat (40) tick();
        check("rx2_no_more_polls", 64'(rxready_reads - snap_c), 64'd0);
        check("rx2_single_read", 64'(rxdata_reads - snap_b), 64'd1);
        check("rx2_still_valid", 64'(rx_valid), 64'd1);
        rx_avail_until = rxdata_reads;
        exp_rx.push_back(8'h52);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("rx2_valid_falls", 64'(rx_valid), 64'd0);
        repeat (20) tick();
        check("rx2_polls_resume", 64'(rxready_reads > snap_c), 64'd1);
        rx_ready = 1'b1;

        // 4. tx byte with TXREADY=0 for 20 polls
        snap_a = txdata_writes;
        snap_b = txready_reads;
        tx_zero_target = txready_reads + 20;
        exp_wr.push_back(wr(3'd4, 32'h0000_000A, 4'b0001));
        send_tx(8'h0A);
        wait_tx_free();
        check("tx1_writes", 64'(txdata_writes - snap_a), 64'd1);
        check("tx1_polls", 64'(txready_reads - snap_b), 64'd21);
        repeat (20) tick();
        check("tx1_no_extra_write", 64'(txdata_writes - snap_a), 64'd1);

        // 5. slave latency 7: hold stable, one write completes
        lat = 7;
        tx_zero_target = txready_reads;
        exp_wr.push_back(wr(3'd4, 32'h0000_0033, 4'b0001));
        send_tx(8'h33);
        wait_tx_free();
        check("lat7_hold_cycles", 64'(last_hold), 64'd8);
        check("lat7_writes_left", 64'(exp_wr.size()), 64'd0);

        // 6. reset during WRITE_TX with valid high
        send_tx(8'h55);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (uart_valid && uart_addr == 3'd4 && uart_wstrb == 4'b0001) begin
                found = 1'b1;
                break;
            end
        end
        check("wr_tx_seen", 64'(found), 64'd1);
        reset = 1'b0;
        tick();
        check_reset_outputs("midreset");
        lat = 0;
        tick();
        push_init();
        reset = 1'b1;
        wait_init("reinit");
        repeat (20) tick();
        check("reinit_no_tx_write", 64'(exp_wr.size()), 64'd0);
        check("rx_queue_drained", 64'(exp_rx.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
